// File: rtl/rs232_pkg.sv
// Shared types and helpers for the RS-232 receiver and the baud tick divider.
// RS232_RX_PARITY_EN adds the PAR state for the even-parity build.
package rs232_pkg;

`ifdef RS232_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} rx_state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_e;
`endif

    localparam int unsigned OVS_SAMPLE_LO  = 7;
    localparam int unsigned OVS_SAMPLE_MID = 8;
    localparam int unsigned OVS_SAMPLE_HI  = 9;

    // Rounded clock divider for the oversampling tick.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        int unsigned den;
        den = baud * ovs;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// Synchronous clear parks the counter at 0 so the tick phase follows the release.
module rs232_baud_tick #(
    parameter int unsigned DIV = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == DIV_M1) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/rs232_rx.sv
// 8N1 RS-232 receiver with 16x oversampling, majority vote and a valid/ready holding register.
// Define RS232_RX_PARITY_EN for 8E1 framing with a parity_err output.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int unsigned CLK_HZ = 48000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned OVS    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_err,
    output logic       overrun_err,
`ifdef RS232_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       break_det
);
    localparam int unsigned DIV = baud_div(CLK_HZ, BAUD, OVS);

    rx_state_e   state, state_n;
    logic [1:0]  sync;
    logic        rxs;
    logic        tick, div_clr;
    logic [3:0]  scnt, scnt_n, scnt_inc;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shift, shift_n;
    logic [1:0]  smp, smp_n;
    logic [7:0]  data_n;
    logic        valid_n, fe_n, oe_n, brk_n;
    logic        vote, at_lo, at_mid, at_hi, at_wrap;
`ifdef RS232_RX_PARITY_EN
    logic        par_bad, par_bad_n, pe_n;
`endif

    assign rxs     = sync[1];
    assign div_clr = (state == IDLE);

    rs232_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (div_clr),
        .tick  (tick)
    );

    // Sample-point strobes fire on the tick that moves scnt onto that position.
    assign scnt_inc = scnt + 4'd1;
    assign at_lo    = tick && (scnt_inc == 4'(OVS_SAMPLE_LO));
    assign at_mid   = tick && (scnt_inc == 4'(OVS_SAMPLE_MID));
    assign at_hi    = tick && (scnt_inc == 4'(OVS_SAMPLE_HI));
    assign at_wrap  = tick && (scnt == 4'd15);
    assign vote     = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync        <= 2'b11;
            state       <= IDLE;
            scnt        <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            smp         <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            par_bad     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            sync        <= {sync[0], rx};
            state       <= state_n;
            scnt        <= scnt_n;
            bit_idx     <= bit_n;
            shift       <= shift_n;
            smp         <= smp_n;
            rx_data     <= data_n;
            rx_valid    <= valid_n;
            framing_err <= fe_n;
            overrun_err <= oe_n;
            break_det   <= brk_n;
`ifdef RS232_RX_PARITY_EN
            par_bad     <= par_bad_n;
            parity_err  <= pe_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bit_n   = bit_idx;
        shift_n = shift;
        smp_n   = smp;
        data_n  = rx_data;
        valid_n = rx_valid;
        fe_n    = 1'b0;
        oe_n    = 1'b0;
        brk_n   = break_det;
`ifdef RS232_RX_PARITY_EN
        par_bad_n = par_bad;
        pe_n      = 1'b0;
`endif
        if (tick) scnt_n = scnt_inc;
        if (at_lo) smp_n[0] = rxs;
        if (at_mid) smp_n[1] = rxs;
        if (rx_valid && rx_ready) valid_n = 1'b0;

        case (state)
            IDLE: begin
                scnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (at_hi && vote) begin
                    state_n = IDLE;
                end else if (at_wrap) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (at_hi) shift_n = {vote, shift[7:1]};
                if (at_wrap) begin
                    bit_n = bit_idx + 3'd1;
`ifdef RS232_RX_PARITY_EN
                    if (bit_idx == 3'd7) state_n = PAR;
`else
                    if (bit_idx == 3'd7) state_n = STOP;
`endif
                end
            end
`ifdef RS232_RX_PARITY_EN
            PAR: begin
                if (at_hi) par_bad_n = vote ^ (^shift);
                if (at_wrap) state_n = STOP;
            end
`endif
            STOP: begin
                // Decide at mid stop bit; the tail of the bit is slack for clock error.
                if (at_hi) begin
                    if (vote) begin
                        state_n = IDLE;
`ifdef RS232_RX_PARITY_EN
                        if (par_bad) pe_n = 1'b1;
                        else
`endif
                        if (!rx_valid || rx_ready) begin
                            data_n  = shift;
                            valid_n = 1'b1;
                        end else begin
                            oe_n = 1'b1;
                        end
                    end else begin
                        state_n = BRK;
                        scnt_n  = '0;
`ifdef RS232_RX_PARITY_EN
                        pe_n = par_bad;
                        if (shift == 8'h00 && !par_bad) brk_n = 1'b1;
`else
                        if (shift == 8'h00) brk_n = 1'b1;
`endif
                        else fe_n = 1'b1;
                    end
                end
            end
            BRK: begin
                // scnt counts consecutive high ticks; any low tick restarts the count.
                if (tick) begin
                    if (!rxs) begin
                        scnt_n = '0;
                    end else if (scnt == 4'd15) begin
                        state_n = IDLE;
                        brk_n   = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rs232_rx.sv
// Self-checking bench for rs232_rx: frame table, randomized frames against a rule model,
// and hand sequences for overrun, glitch, break, mid-frame reset and parity.
module tb_rs232_rx;
    localparam int BIT_CLKS = 417;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun_err;
    logic       break_det;
`ifdef RS232_RX_PARITY_EN
    logic       parity_err;
`endif

    rs232_rx dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
`ifdef RS232_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .break_det   (break_det)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int cnt_fe = 0, cnt_oe = 0, cnt_brk = 0, cnt_pe = 0, cnt_v = 0;
    int b_fe, b_oe, b_brk, b_pe, b_v;
    int brk_rise_cyc = 0, brk_fall_cyc = 0;
    logic brk_q = 1'b0;
    logic [7:0] rxq[$];

    always @(posedge clk) cyc++;

    // Monitor: counts pulses and collects accepted bytes, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (framing_err) cnt_fe++;
            if (overrun_err) cnt_oe++;
`ifdef RS232_RX_PARITY_EN
            if (parity_err) cnt_pe++;
`endif
            if (rx_valid) cnt_v++;
            if (break_det && !brk_q) begin cnt_brk++; brk_rise_cyc = cyc; end
            if (!break_det && brk_q) brk_fall_cyc = cyc;
            brk_q = break_det;
            if (rx_valid && rx_ready) rxq.push_back(rx_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected within [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip);
        logic [11:0] f;
`ifdef RS232_RX_PARITY_EN
        f = {1'b1, stop_ok, (^d) ^ par_flip, d, 1'b0};
        drive_bits(f, 11);
`else
        f = {2'b11, stop_ok, d, 1'b0};
        if (par_flip) f[11] = 1'b1;
        drive_bits(f, 10);
`endif
        rx = 1'b1;
    endtask

    task automatic snap();
        b_fe = cnt_fe; b_oe = cnt_oe; b_brk = cnt_brk; b_pe = cnt_pe; b_v = cnt_v;
        rxq.delete();
    endtask

    task automatic check_frame(input string tag, input int nb, input logic [7:0] d,
                               input int fe, input int brk, input int pe);
        check({tag, " bytes"}, rxq.size(), nb);
        if (nb == 1 && rxq.size() == 1) check({tag, " data"}, {24'd0, rxq[0]}, {24'd0, d});
        check({tag, " valid_cycles"}, cnt_v - b_v, nb);
        check({tag, " framing_err"}, cnt_fe - b_fe, fe);
        check({tag, " break"}, cnt_brk - b_brk, brk);
        check({tag, " overrun_err"}, cnt_oe - b_oe, 0);
`ifdef RS232_RX_PARITY_EN
        check({tag, " parity_err"}, cnt_pe - b_pe, pe);
`else
        check({tag, " parity_err"}, cnt_pe - b_pe, 0);
        if (pe != 0) check({tag, " parity_req"}, pe, 0);
`endif
    endtask

    // Line-level rules: good stop and parity -> byte; low stop on all-zero data -> break;
    // other low stop -> framing error; parity mismatch always flagged.
    task automatic model_frame(input logic [7:0] d, input logic stop_ok, input logic flip,
                               output int nb, output int fe, output int brk, output int pe);
        pe  = flip ? 1 : 0;
        nb  = (stop_ok && !flip) ? 1 : 0;
        brk = (!stop_ok && d == 8'h00 && !flip) ? 1 : 0;
        fe  = (!stop_ok && brk == 0) ? 1 : 0;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop_ok;
        int         exp_nb;
        logic [7:0] exp_data;
        int         exp_fe;
        int         exp_brk;
    } vec_t;

    vec_t vt[4];
    logic [7:0] d;
    logic ok, flip;
    int e_nb, e_fe, e_brk, e_pe, t0;

    initial begin
        vt[0] = '{8'h5A, 1'b1, 1, 8'h5A, 0, 0};
        vt[1] = '{8'h33, 1'b0, 0, 8'h00, 1, 0};
        vt[2] = '{8'hA5, 1'b1, 1, 8'hA5, 0, 0};
        vt[3] = '{8'h00, 1'b1, 1, 8'h00, 0, 0};

        reset = 1'b1; rx = 1'b1; rx_ready = 1'b1;
        wait_clks(5);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        check("reset errors", {framing_err, overrun_err, break_det}, 0);
        reset = 1'b0;
        wait_clks(50);
        check("post-reset rx_valid", rx_valid, 0);

        for (int i = 0; i < 4; i++) begin
            snap();
            send_frame(vt[i].d, vt[i].stop_ok, 1'b0);
            wait_clks(600);
            check_frame($sformatf("vec%0d", i), vt[i].exp_nb, vt[i].exp_data,
                        vt[i].exp_fe, vt[i].exp_brk, 0);
        end

        for (int k = 0; k < 5; k++) begin
            d    = 8'($urandom);
            ok   = ($urandom_range(0, 3) != 0);
            flip = 1'b0;
`ifdef RS232_RX_PARITY_EN
            flip = ($urandom_range(0, 3) == 0);
`endif
            if (k == 4) begin d = 8'h00; ok = 1'b0; flip = 1'b0; end
            model_frame(d, ok, flip, e_nb, e_fe, e_brk, e_pe);
            snap();
            send_frame(d, ok, flip);
            wait_clks($urandom_range(600, 800));
            check_frame($sformatf("rand%0d d=%02h stop=%0d", k, d, ok), e_nb, d, e_fe, e_brk, e_pe);
        end

        // Two frames back to back with the consumer stalled.
        rx_ready = 1'b0;
        snap();
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        wait_clks(100);
        check("ovr rx_valid", rx_valid, 1);
        check("ovr rx_data", rx_data, 8'h01);
        check("ovr overrun count", cnt_oe - b_oe, 1);
        check("ovr framing", cnt_fe - b_fe, 0);
        rx_ready = 1'b1;
        wait_clks(3);
        check("ovr drain rx_valid", rx_valid, 0);
        check("ovr drain rx_data", rx_data, 8'h01);
        check("ovr drained bytes", rxq.size(), 1);

        // Half-bit glitch, then a real frame to prove the receiver resynchronised.
        snap();
        rx = 1'b0; wait_clks(208);
        rx = 1'b1; wait_clks(600);
        check_frame("glitch", 0, 8'h00, 0, 0, 0);
        snap();
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_clks(600);
        check_frame("after glitch", 1, 8'h3C, 0, 0, 0);

        // Long break.
        snap();
        t0 = cyc;
        rx = 1'b0;
        wait_clks(20 * BIT_CLKS);
        check("brk held", break_det, 1);
        check("brk count", cnt_brk - b_brk, 1);
`ifdef RS232_RX_PARITY_EN
        check_rng("brk rise delay", brk_rise_cyc - t0, 4370, 4440);
`else
        check_rng("brk rise delay", brk_rise_cyc - t0, 3950, 4020);
`endif
        t0 = cyc;
        rx = 1'b1;
        wait_clks(600);
        check("brk cleared", break_det, 0);
        check_rng("brk fall delay", brk_fall_cyc - t0, 380, 440);
        check("brk framing", cnt_fe - b_fe, 0);

        // Reset in the middle of data bit 4 of 0xFF while a byte is held.
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0);
        wait_clks(100);
        check("pre-reset rx_valid", rx_valid, 1);
        drive_bits(12'hFFE, 5);
        wait_clks(200);
        reset = 1'b1;
        #1;
        check("midreset rx_valid", rx_valid, 0);
        check("midreset rx_data", rx_data, 0);
        check("midreset errors", {framing_err, overrun_err, break_det}, 0);
        wait_clks(4);
        reset = 1'b0;
        rx_ready = 1'b1;
        wait_clks(5 * BIT_CLKS);
        snap();
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_clks(600);
        check_frame("after reset", 1, 8'hC3, 0, 0, 0);

`ifdef RS232_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(600);
        check_frame("parity 0x07", 0, 8'h00, 0, 0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
